// File: rtl/q_pkg.sv
// Shared definitions for the Q-learning policy reader and the Q-update datapath:
// table geometry, scan FSM encoding and the 16-bit LFSR step function.
package q_pkg;

  localparam int N_ACT = 16;
  localparam int Q_W   = 16;
  localparam int S_W   = 4;
  localparam int ACT_W = $clog2(N_ACT);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  // One step of the maximal-length Galois LFSR
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    lfsr16_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/q_policy_reader_lfsr16.sv
// Free-running 16-bit maximal Galois LFSR used as the exploration random source.
module lfsr16
  import q_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  // An all-zero seed would lock the register, so fall back to the package seed
  localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? q_pkg::LFSR_SEED : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value, advanced unconditionally every cycle
  always_comb begin
    lfsr_d = lfsr16_next(lfsr_q);
  end

  // LFSR state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SAFE_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/q_policy_reader.sv
// Epsilon-greedy policy lookup: scans all actions of one Q-table state,
// tracks the signed argmax and picks either it or an LFSR-drawn action.
module q_policy_reader
  import q_pkg::*;
#(
  parameter int          N_ACT     = q_pkg::N_ACT,
  parameter int          Q_W       = q_pkg::Q_W,
  parameter int          S_W       = q_pkg::S_W,
  parameter logic [15:0] LFSR_SEED = q_pkg::LFSR_SEED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [S_W-1:0]           state,
  input  logic [15:0]              epsilon,
  output logic                     rd_en,
  output logic [S_W-1:0]           rd_addr,
  output logic [$clog2(N_ACT)-1:0] rd_action,
  input  logic [Q_W-1:0]           rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_ACT)-1:0] best_action,
  output logic [Q_W-1:0]           best_q,
  output logic [$clog2(N_ACT)-1:0] chosen_action,
  output logic                     explored
);

  localparam int AW = $clog2(N_ACT);
  localparam logic [AW-1:0] LAST_ACT = AW'(N_ACT - 1);

  scan_state_e   state_q, state_d;
  logic          rd_en_q, rd_en_d;
  logic [S_W-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] rd_action_q, rd_action_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [Q_W-1:0] max_q, max_d;
  logic [AW-1:0] arg_q, arg_d;
  logic [AW-1:0] best_action_q, best_action_d;
  logic [Q_W-1:0] best_q_q, best_q_d;
  logic [AW-1:0] chosen_q, chosen_d;
  logic          explored_q, explored_d;
  logic [15:0]   lfsr_val;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_val)
  );

  // Next-state, read sequencing, running argmax and decision logic
  always_comb begin
    state_d       = state_q;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_action_d   = rd_action_q;
    done_d        = 1'b0;
    max_d         = max_q;
    arg_d         = arg_q;
    best_action_d = best_action_q;
    best_q_d      = best_q_q;
    chosen_d      = chosen_q;
    explored_d    = explored_q;

    // Data on rd_data belongs to the read strobed this cycle; action 0 seeds
    // the max, later actions replace it only when strictly greater (signed)
    if (rd_en_q) begin
      if ((rd_action_q == {AW{1'b0}}) || ($signed(rd_data) > $signed(max_q))) begin
        max_d = rd_data;
        arg_d = rd_action_q;
      end else begin
        max_d = max_q;
        arg_d = arg_q;
      end
    end else begin
      max_d = max_q;
      arg_d = arg_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SCAN;
          rd_en_d     = 1'b1;
          rd_addr_d   = state;
          rd_action_d = {AW{1'b0}};
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (rd_action_q == LAST_ACT) begin
          state_d     = ST_DRAIN;
          rd_en_d     = 1'b0;
          rd_action_d = {AW{1'b0}};
        end else begin
          rd_en_d     = 1'b1;
          rd_action_d = rd_action_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Final sample was folded in on entry here; publish the result
        state_d       = ST_IDLE;
        done_d        = 1'b1;
        best_action_d = arg_q;
        best_q_d      = max_q;
        if (lfsr_val < epsilon) begin
          chosen_d   = lfsr_val[AW-1:0];
          explored_d = 1'b1;
        end else begin
          chosen_d   = arg_q;
          explored_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rd_action_d = {AW{1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= {S_W{1'b0}};
      rd_action_q   <= {AW{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      max_q         <= {Q_W{1'b0}};
      arg_q         <= {AW{1'b0}};
      best_action_q <= {AW{1'b0}};
      best_q_q      <= {Q_W{1'b0}};
      chosen_q      <= {AW{1'b0}};
      explored_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      rd_action_q   <= rd_action_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      max_q         <= max_d;
      arg_q         <= arg_d;
      best_action_q <= best_action_d;
      best_q_q      <= best_q_d;
      chosen_q      <= chosen_d;
      explored_q    <= explored_d;
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;
  assign rd_action     = rd_action_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign best_action   = best_action_q;
  assign best_q        = best_q_q;
  assign chosen_action = chosen_q;
  assign explored      = explored_q;

endmodule

// File: tb/tb_q_policy_reader.sv
// Directed bench for q_policy_reader: small Q-table model, independent LFSR
// reference, cycle-exact read sequence and result checks.
module tb_q_policy_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  st_in;
  logic [15:0] epsilon;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [3:0]  rd_action;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  best_action;
  logic [15:0] best_q;
  logic [3:0]  chosen_action;
  logic        explored;

  logic [15:0] qtab [16][16];
  logic [15:0] lfsr_m;
  logic [15:0] snap;
  int          lat;
  int          done_seen;
  int          n_total;
  int          n_bad;

  q_policy_reader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .state         (st_in),
    .epsilon       (epsilon),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_action     (rd_action),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .best_action   (best_action),
    .best_q        (best_q),
    .chosen_action (chosen_action),
    .explored      (explored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q-table model: data for the strobed address is presented during the strobe cycle
  assign rd_data = qtab[rd_addr][rd_action];

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
    ref_lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR, taps 16,14,13,11, seed 0xACE1
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= ref_lfsr_next(lfsr_m);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge. Issues start for state st, optionally pokes
  // start (with a different state) at scan cycle poke_at, and returns the
  // LFSR value that was live in the cycle before done plus the done latency.
  task automatic do_lookup(input logic [3:0] st, input int poke_at,
                           output logic [15:0] lf_snap, output int lat_o);
    start = 1'b1;
    st_in = st;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat_o = 1;
    lf_snap = 16'h0000;
    while (done !== 1'b1 && lat_o < 40) begin
      check_val("rd_en", 32'(rd_en), 32'(lat_o <= 16));
      if (lat_o <= 16) begin
        check_val("rd_action", 32'(rd_action), 32'(lat_o - 1));
        check_val("rd_addr", 32'(rd_addr), 32'(st));
      end
      check_val("busy", 32'(busy), 32'd1);
      if (lat_o == poke_at) begin
        start = 1'b1;
        st_in = st ^ 4'hF;
      end else begin
        start = 1'b0;
        st_in = st;
      end
      lf_snap = lfsr_m;
      @(negedge clk);
      lat_o++;
    end
    start = 1'b0;
    check_val("latency", 32'(lat_o), 32'd18);
    check_val("busy_at_done", 32'(busy), 32'd0);
    check_val("rd_en_at_done", 32'(rd_en), 32'd0);
  endtask

  task automatic check_result(input logic [3:0] eb, input logic [15:0] eq,
                              input logic [15:0] eps, input logic [15:0] lf);
    logic       ex;
    logic [3:0] ec;
    ex = (lf < eps);
    ec = ex ? lf[3:0] : eb;
    check_val("best_action", 32'(best_action), 32'(eb));
    check_val("best_q", 32'(best_q), 32'(eq));
    check_val("chosen_action", 32'(chosen_action), 32'(ec));
    check_val("explored", 32'(explored), 32'(ex));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    st_in   = 4'd0;
    epsilon = 16'h0000;
    for (int s = 0; s < 16; s++)
      for (int a = 0; a < 16; a++)
        qtab[s][a] = 16'h0000;
    // state 3: flat 1.0 with a single peak at a9
    for (int a = 0; a < 16; a++) qtab[3][a] = 16'h0100;
    qtab[3][9] = 16'h0480;
    // state 5: all negative; a5 = -1.0 is the maximum
    for (int a = 0; a < 16; a++) qtab[5][a] = 16'hF000;
    qtab[5][0]  = 16'hFE00;
    qtab[5][5]  = 16'hFF00;
    qtab[5][12] = 16'h8000;
    // state 7: all equal
    for (int a = 0; a < 16; a++) qtab[7][a] = 16'h0200;
    // state 1: peak at a4
    qtab[1][4] = 16'h7FFF;
    // state 2: peak at the last action
    for (int a = 0; a < 16; a++) qtab[2][a] = 16'h0010;
    qtab[2][3]  = 16'h02FF;
    qtab[2][15] = 16'h0300;

    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_rd_en", 32'(rd_en), 32'd0);
    check_val("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_val("rst_rd_action", 32'(rd_action), 32'd0);
    check_val("rst_best_action", 32'(best_action), 32'd0);
    check_val("rst_best_q", 32'(best_q), 32'd0);
    check_val("rst_chosen", 32'(chosen_action), 32'd0);
    check_val("rst_explored", 32'(explored), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single peak, greedy only
    epsilon = 16'h0000;
    do_lookup(4'd3, 0, snap, lat);
    check_result(4'd9, 16'h0480, 16'h0000, snap);
    check_val("greedy_chosen", 32'(chosen_action), 32'd9);
    // Result holds and done is a single-cycle pulse
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("done_pulse", 32'(done), 32'd0);
      check_val("hold_best", 32'(best_action), 32'd9);
      check_val("hold_q", 32'(best_q), 32'h0480);
    end

    // Signed compare with start poked mid-scan, then back-to-back start on done
    do_lookup(4'd5, 5, snap, lat);
    check_result(4'd5, 16'hFF00, 16'h0000, snap);
    do_lookup(4'd7, 17, snap, lat);
    check_result(4'd0, 16'h0200, 16'h0000, snap);

    // Reset in the middle of a scan aborts it
    @(negedge clk);
    start = 1'b1;
    st_in = 4'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_rd_en", 32'(rd_en), 32'd0);
    check_val("abort_rd_action", 32'(rd_action), 32'd0);
    check_val("abort_best_q", 32'(best_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check_val("abort_no_done", 32'(done_seen), 32'd0);

    // Fresh scan after abort, with start poked while busy
    do_lookup(4'd2, 8, snap, lat);
    check_result(4'd15, 16'h0300, 16'h0000, snap);

    // Full exploration threshold
    epsilon = 16'hFFFF;
    for (int i = 0; i < 100; i++) begin
      do_lookup(4'd3, 0, snap, lat);
      check_result(4'd9, 16'h0480, 16'hFFFF, snap);
    end

    // Mid threshold mixes explored and greedy choices
    epsilon = 16'h8000;
    for (int i = 0; i < 20; i++) begin
      do_lookup(4'd5, 0, snap, lat);
      check_result(4'd5, 16'hFF00, 16'h8000, snap);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
